// File: rtl/voice_output_mixer_if.sv
// Voice-side and output-side signal bundle for voice_output_mixer.
// The master drives voice samples and output acceptance; the slave is the mixer.
interface voice_output_mixer_if #(
  parameter int unsigned NUMVOICES = 12,
  parameter int unsigned VOICE_AW  = 4,
  parameter int unsigned DW        = 32,
  parameter int unsigned OW        = 32
);
  logic                 voice_valid;
  logic [VOICE_AW-1:0]  voice_idx;
  logic [DW-1:0]        voice_sample;
  logic [NUMVOICES-1:0] voice_mask;
  logic                 out_ready;
  logic                 clr_flags;
  logic [OW-1:0]        out_sample;
  logic                 out_valid;
  logic                 busy;
  logic                 overrun;
  logic                 frame_err;

  modport master (
    output voice_valid, voice_idx, voice_sample, voice_mask, out_ready, clr_flags,
    input  out_sample, out_valid, busy, overrun, frame_err
  );

  modport slave (
    input  voice_valid, voice_idx, voice_sample, voice_mask, out_ready, clr_flags,
    output out_sample, out_valid, busy, overrun, frame_err
  );
endinterface

// File: rtl/voice_output_mixer.sv
// Per-frame voice mixer: accumulates masked voices in index order, then scales,
// saturates and presents one signed sample per frame through a valid/ready hold register.
module voice_output_mixer #(
  parameter int unsigned NUMVOICES = 12,
  parameter int unsigned VOICE_AW  = 4,
  parameter int unsigned DW        = 32,
  parameter int unsigned ACCW      = DW + VOICE_AW,
  parameter int unsigned SHIFT     = 4,
  parameter int unsigned OW        = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  voice_output_mixer_if.slave  bus
);

  localparam logic [VOICE_AW-1:0] LAST_IDX = VOICE_AW'(NUMVOICES - 1);
  localparam logic [OW-1:0]       SAT_MAX  = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0]       SAT_MIN  = {1'b1, {(OW-1){1'b0}}};

  typedef enum logic [0:0] {ST_IDLE, ST_ACCUM} state_t;

  state_t                  r_state, w_state_nxt;
  logic signed [ACCW-1:0]  r_acc, w_acc_nxt;
  logic [VOICE_AW-1:0]     r_exp, w_exp_nxt;
  logic [OW-1:0]           r_out_sample, w_out_sample_nxt;
  logic                    r_out_valid, w_out_valid_nxt;
  logic                    r_busy, w_busy_nxt;
  logic                    r_overrun, w_overrun_nxt;
  logic                    r_frame_err, w_frame_err_nxt;

  logic                    w_in_range;
  logic                    w_sel;
  logic signed [ACCW-1:0]  w_contrib;
  logic signed [ACCW-1:0]  w_sum;
  logic signed [ACCW-1:0]  w_shifted;
  logic [OW-1:0]           w_sat;
  logic                    w_complete;
  logic                    w_seq_err;

  // Indices beyond NUMVOICES have no mask bit and never contribute.
  assign w_in_range = (32'(bus.voice_idx) < NUMVOICES);
  assign w_sel      = w_in_range && bus.voice_mask[bus.voice_idx];
  assign w_contrib  = w_sel ? {{(ACCW-DW){bus.voice_sample[DW-1]}}, bus.voice_sample} : '0;
  assign w_sum      = r_acc + w_contrib;
  assign w_shifted  = w_sum >>> SHIFT;

  // Clamp when the bits above the output sign bit are not a pure sign extension.
  always_comb begin
    w_sat = w_shifted[OW-1:0];
    if (!((w_shifted[ACCW-1:OW-1] == '0) || (w_shifted[ACCW-1:OW-1] == '1))) begin
      w_sat = w_shifted[ACCW-1] ? SAT_MIN : SAT_MAX;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_acc_nxt        = r_acc;
    w_exp_nxt        = r_exp;
    w_out_sample_nxt = r_out_sample;
    w_out_valid_nxt  = r_out_valid;
    w_overrun_nxt    = r_overrun;
    w_frame_err_nxt  = r_frame_err;
    w_busy_nxt       = r_busy;
    w_complete       = 1'b0;
    w_seq_err        = 1'b0;

    if (bus.voice_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (bus.voice_idx == '0) begin
            if (NUMVOICES == 1) begin
              w_complete = 1'b1;
            end else begin
              w_acc_nxt   = w_contrib;
              w_exp_nxt   = VOICE_AW'(1);
              w_state_nxt = ST_ACCUM;
            end
          end else begin
            w_seq_err = 1'b1;
          end
        end
        ST_ACCUM: begin
          if (bus.voice_idx == r_exp) begin
            if (r_exp == LAST_IDX) begin
              w_complete  = 1'b1;
              w_acc_nxt   = '0;
              w_exp_nxt   = '0;
              w_state_nxt = ST_IDLE;
            end else begin
              w_acc_nxt = w_sum;
              w_exp_nxt = r_exp + VOICE_AW'(1);
            end
          end else begin
            w_seq_err = 1'b1;
            // A fresh voice 0 restarts the frame rather than waiting for the next one.
            if (bus.voice_idx == '0) begin
              w_acc_nxt = w_contrib;
              w_exp_nxt = VOICE_AW'(1);
            end else begin
              w_acc_nxt   = '0;
              w_exp_nxt   = '0;
              w_state_nxt = ST_IDLE;
            end
          end
        end
      endcase
    end

    if (r_out_valid && bus.out_ready) begin
      w_out_valid_nxt = 1'b0;
    end
    if (w_complete) begin
      w_out_sample_nxt = w_sat;
      w_out_valid_nxt  = 1'b1;
    end

    // Sticky flags: a set on the same edge as a clear takes priority.
    if (bus.clr_flags) begin
      w_overrun_nxt   = 1'b0;
      w_frame_err_nxt = 1'b0;
    end
    if (w_complete && r_out_valid && !bus.out_ready) begin
      w_overrun_nxt = 1'b1;
    end
    if (w_seq_err) begin
      w_frame_err_nxt = 1'b1;
    end

    w_busy_nxt = (w_state_nxt == ST_ACCUM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_acc        <= '0;
      r_exp        <= '0;
      r_out_sample <= '0;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_acc        <= w_acc_nxt;
      r_exp        <= w_exp_nxt;
      r_out_sample <= w_out_sample_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_busy       <= w_busy_nxt;
      r_overrun    <= w_overrun_nxt;
      r_frame_err  <= w_frame_err_nxt;
    end
  end

  assign bus.out_sample = r_out_sample;
  assign bus.out_valid  = r_out_valid;
  assign bus.busy       = r_busy;
  assign bus.overrun    = r_overrun;
  assign bus.frame_err  = r_frame_err;

endmodule

// File: tb/tb_voice_output_mixer.sv
// Scoreboard bench for voice_output_mixer: two instances (SHIFT=4 and SHIFT=0) share
// one stimulus stream and are compared each cycle against a behavioural frame model.
module tb_voice_output_mixer;

  localparam int unsigned NV = 12;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned OW = 32;
  localparam longint      LIM_MAX = 64'sd2147483647;
  localparam longint      LIM_MIN = -LIM_MAX - 64'sd1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  voice_output_mixer_if #(.NUMVOICES(NV), .VOICE_AW(AW), .DW(DW), .OW(OW)) vif ();
  voice_output_mixer_if #(.NUMVOICES(NV), .VOICE_AW(AW), .DW(DW), .OW(OW)) vif0 ();

  assign vif0.voice_valid  = vif.voice_valid;
  assign vif0.voice_idx    = vif.voice_idx;
  assign vif0.voice_sample = vif.voice_sample;
  assign vif0.voice_mask   = vif.voice_mask;
  assign vif0.out_ready    = vif.out_ready;
  assign vif0.clr_flags    = vif.clr_flags;

  voice_output_mixer #(.NUMVOICES(NV), .VOICE_AW(AW), .DW(DW), .SHIFT(4), .OW(OW))
    u_dut (.clk(clk), .rst_n(rst_n), .bus(vif));
  voice_output_mixer #(.NUMVOICES(NV), .VOICE_AW(AW), .DW(DW), .SHIFT(0), .OW(OW))
    u_dut_s0 (.clk(clk), .rst_n(rst_n), .bus(vif0));

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] q4[$];
  logic [31:0] q0[$];

  // Reference model state
  bit     m_busy, m_ov, m_ovr, m_ferr, m_done;
  longint m_acc;
  int     m_exp;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] sat32(input longint v);
    if (v > LIM_MAX) return 32'h7FFF_FFFF;
    if (v < LIM_MIN) return 32'h8000_0000;
    return v[31:0];
  endfunction

  task automatic model_reset();
    m_busy = 0; m_ov = 0; m_ovr = 0; m_ferr = 0; m_done = 0;
    m_acc = 0; m_exp = 0;
    q4.delete(); q0.delete();
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    longint contrib, fin;
    bit done, ferr_set, ovr_set;
    int idx;
    done = 0; ferr_set = 0; contrib = 0; fin = 0;
    idx = int'(vif.voice_idx);
    if (vif.voice_valid) begin
      if (idx < NV && vif.voice_mask[idx]) contrib = longint'($signed(vif.voice_sample));
      if (!m_busy) begin
        if (idx == 0) begin m_acc = contrib; m_exp = 1; m_busy = 1; end
        else ferr_set = 1;
      end else if (idx == m_exp) begin
        if (m_exp == NV - 1) begin
          fin = m_acc + contrib; done = 1; m_busy = 0; m_acc = 0; m_exp = 0;
        end else begin
          m_acc = m_acc + contrib; m_exp++;
        end
      end else begin
        ferr_set = 1;
        if (idx == 0) begin m_acc = contrib; m_exp = 1; end
        else begin m_busy = 0; m_acc = 0; m_exp = 0; end
      end
    end
    ovr_set = done && m_ov && !vif.out_ready;
    if (m_ov && vif.out_ready) m_ov = 0;
    if (done) begin
      m_ov = 1;
      q4.push_back(sat32(fin >>> 4));
      q0.push_back(sat32(fin));
    end
    if (vif.clr_flags) begin m_ovr = 0; m_ferr = 0; end
    if (ovr_set) m_ovr = 1;
    if (ferr_set) m_ferr = 1;
    m_done = done;
  endtask

  task automatic check_state();
    chk("busy",      64'(vif.busy),       64'(m_busy));
    chk("out_valid", 64'(vif.out_valid),  64'(m_ov));
    chk("overrun",   64'(vif.overrun),    64'(m_ovr));
    chk("frame_err", 64'(vif.frame_err),  64'(m_ferr));
    chk("s0_busy",      64'(vif0.busy),      64'(m_busy));
    chk("s0_out_valid", 64'(vif0.out_valid), 64'(m_ov));
    chk("s0_overrun",   64'(vif0.overrun),   64'(m_ovr));
    chk("s0_frame_err", 64'(vif0.frame_err), 64'(m_ferr));
    if (m_done) begin
      if (q4.size() > 0) chk("sample_sh4", 64'(vif.out_sample),  64'(q4.pop_front()));
      if (q0.size() > 0) chk("sample_sh0", 64'(vif0.out_sample), 64'(q0.pop_front()));
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_sample"},    64'(vif.out_sample),  64'd0);
    chk({tag, "_valid"},     64'(vif.out_valid),   64'd0);
    chk({tag, "_busy"},      64'(vif.busy),        64'd0);
    chk({tag, "_overrun"},   64'(vif.overrun),     64'd0);
    chk({tag, "_frame_err"}, 64'(vif.frame_err),   64'd0);
    chk({tag, "_s0_sample"}, 64'(vif0.out_sample), 64'd0);
    chk({tag, "_s0_valid"},  64'(vif0.out_valid),  64'd0);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic voice(input int idx, input logic [31:0] s);
    vif.voice_valid  = 1'b1;
    vif.voice_idx    = AW'(idx);
    vif.voice_sample = s;
    cycle();
  endtask

  task automatic idle(input int n);
    vif.voice_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic frame(input logic [31:0] s);
    for (int i = 0; i < NV; i++) voice(i, s);
    vif.voice_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vif.voice_valid  = 1'b0;
    vif.voice_idx    = '0;
    vif.voice_sample = '0;
    vif.voice_mask   = 12'hFFF;
    vif.out_ready    = 1'b1;
    vif.clr_flags    = 1'b0;
    model_reset();
    #12;
    check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic mix
    frame(32'h0100_0000);
    chk("basic_sample", 64'(vif.out_sample), 64'h00C0_0000);
    chk("basic_valid",  64'(vif.out_valid),  64'd1);
    idle(2);

    // Saturation (SHIFT=0 instance)
    frame(32'h7FFF_FFFF);
    chk("sat_pos", 64'(vif0.out_sample), 64'h7FFF_FFFF);
    idle(1);
    frame(32'h8000_0000);
    chk("sat_neg", 64'(vif0.out_sample), 64'h8000_0000);
    chk("sat_no_ferr", 64'(vif.frame_err), 64'd0);
    idle(2);

    // Mask: only voice 3 routed
    vif.voice_mask = 12'h008;
    for (int i = 0; i < NV; i++) voice(i, (i == 3) ? 32'h10 : 32'h1000);
    chk("mask_sample", 64'(vif.out_sample), 64'h1);
    vif.voice_mask = 12'hFFF;
    idle(2);

    // Sequence error then clean frame, then flag clear
    voice(0, 32'h100); voice(1, 32'h100); voice(2, 32'h100); voice(5, 32'h100);
    idle(1);
    chk("seq_ferr",  64'(vif.frame_err), 64'd1);
    chk("seq_busy",  64'(vif.busy),      64'd0);
    chk("seq_valid", 64'(vif.out_valid), 64'd0);
    frame(32'h0100_0000);
    chk("seq_recover", 64'(vif.out_sample), 64'h00C0_0000);
    vif.clr_flags = 1'b1;
    idle(1);
    vif.clr_flags = 1'b0;
    chk("clr_ferr", 64'(vif.frame_err), 64'd0);
    // Clear coinciding with a new sequence error: the set wins
    vif.clr_flags = 1'b1;
    voice(3, 32'h1);
    vif.clr_flags = 1'b0;
    chk("clr_vs_set", 64'(vif.frame_err), 64'd1);
    idle(1);

    // Overrun and handshake
    vif.out_ready = 1'b0;
    frame(32'h100);
    frame(32'h200);
    chk("ovr_sample", 64'(vif.out_sample), 64'h180);
    chk("ovr_flag",   64'(vif.overrun),    64'd1);
    chk("ovr_valid",  64'(vif.out_valid),  64'd1);
    vif.out_ready = 1'b1;
    idle(1);
    vif.out_ready = 1'b0;
    chk("xfer_valid", 64'(vif.out_valid), 64'd0);
    frame(32'h300);
    for (int i = 0; i < NV - 1; i++) voice(i, 32'h400);
    vif.out_ready = 1'b1;
    voice(NV - 1, 32'h400);
    vif.voice_valid = 1'b0;
    chk("coinc_valid",  64'(vif.out_valid),  64'd1);
    chk("coinc_sample", 64'(vif.out_sample), 64'h300);
    idle(2);
    vif.clr_flags = 1'b1;
    idle(1);
    vif.clr_flags = 1'b0;

    // Reset in the middle of a frame
    for (int i = 0; i <= 5; i++) voice(i, 32'h0100_0000);
    rst_n = 1'b0;
    #1;
    check_reset("midreset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 6; i < NV; i++) voice(i, 32'h0100_0000);
    vif.voice_valid = 1'b0;
    chk("postrst_ferr",  64'(vif.frame_err), 64'd1);
    chk("postrst_valid", 64'(vif.out_valid), 64'd0);
    frame(32'h0100_0000);
    chk("postrst_sample", 64'(vif.out_sample), 64'h00C0_0000);
    idle(2);

    chk("queue_drained", 64'(q4.size() + q0.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/voice_output_mixer.md
# voice_output_mixer

Per-frame audio mixer between the voice pipeline and the I2S output. Consumes one interpolated oscillator sample per voice, in voice-counter order. Accumulates the voices enabled by an output mask, then scales and saturates the sum. Presents one signed sample per frame to i2s_core (i2sDin) through a valid/ready hold register.

## Interface
- NUMVOICES, 12, voices per frame; legal range ≥1.
- VOICE_AW, 4, voice index width; must satisfy 2^VOICE_AW ≥ NUMVOICES.
- DW, 32, signed voice sample width.
- ACCW, DW+VOICE_AW, signed accumulator width; guarantees no internal overflow.
- SHIFT, 4, arithmetic right shift applied to the final sum; legal range 0..ACCW-1.
- OW, 32, signed output width; OW ≤ ACCW.
- Clk  in  1  single clock; all logic on posedge.
- Reset_n  in  1  reset, asynchronous and active-low.
- voice_valid  in  1  voice sample present this cycle; driven by the voice counter enable.
- voice_idx  in  VOICE_AW  index of the presented voice.
- voice_sample  in  DW  signed voice output.
- voice_mask  in  NUMVOICES  bit v=1 routes voice v to the mix; sampled at acceptance.
- out_ready  in  1  consumer accepts out_sample this cycle.
- clr_flags  in  1  synchronous clear of sticky flags.
- out_sample  out  OW  mixed, scaled, saturated sample.
- out_valid  out  1  out_sample holds an unconsumed frame.
- busy  out  1  frame accumulation in progress (state ACCUM).
- overrun  out  1  sticky flag: an unconsumed frame was overwritten.
- frame_err  out  1  sticky flag: a voice arrived out of sequence.

## Operation
**Contribution**
- contrib = voice_mask[voice_idx] ? sign-extend(voice_sample) to ACCW : 0.
- A masked-off voice still advances the sequence.

**States:** IDLE, ACCUM. The block keeps an expected index `exp` (VOICE_AW bits).

**IDLE**
- voice_valid with idx=0 and NUMVOICES=1: the frame completes immediately; stay in IDLE.
- voice_valid with idx=0 and NUMVOICES>1: acc=contrib, exp=1, go to ACCUM.
- voice_valid with idx≠0: set frame_err, discard the sample, stay in IDLE.

**ACCUM**
- voice_valid with idx=exp and exp<NUMVOICES-1: acc+=contrib, exp++.
- voice_valid with idx=exp=NUMVOICES-1: the frame completes; go to IDLE.
- voice_valid with idx≠exp: set frame_err and discard the partial sum.
  - If idx=0: restart (acc=contrib, exp=1, stay in ACCUM).
  - Otherwise: go to IDLE.
- voice_valid low: hold all state. There is no timeout.

**Frame completion**
- final = (acc+contrib) >>> SHIFT.
- Saturate final to OW signed: >2^(OW-1)-1 gives 0x7FFF_FFFF; <-2^(OW-1) gives 0x8000_0000 (OW=32).
- Load out_sample and set out_valid.

**Output handshake**
- A transfer occurs on an edge where out_valid=1 and out_ready=1.
- out_valid clears on transfer, unless a frame completes on the same edge. In that case the new value loads and out_valid stays 1.
- Frame completes while out_valid=1 and out_ready=0: overwrite out_sample and set overrun. The newest frame always wins.

**Flags**
- clr_flags clears overrun and frame_err.
- If clr_flags coincides with a new set condition, the set wins.

**Reset (Reset_n=0, asynchronous)**
- out_sample=0, out_valid=0, busy=0, overrun=0, frame_err=0.
- state=IDLE, acc=0, exp=0.
- Reset mid-frame discards the partial sum. The next frame must start at idx 0.

## Timing
- Each accepted voice_valid updates acc/exp on that edge.
- out_sample and out_valid are registered. Latency is 1 cycle: they update on the edge that accepts the last voice and are visible the following cycle.
- The block accepts one voice per cycle back-to-back, so the minimum frame is NUMVOICES cycles.
- There is no backpressure on the voice side; voices are always accepted.
- out_ready is sampled only on edges where out_valid=1.
- busy is high exactly while state=ACCUM.

## Test plan
- **Basic mix:** 12 voices, idx 0..11 back-to-back, all samples 0x0100_0000, mask 0xFFF, SHIFT=4 → one cycle after idx 11, out_valid=1 and out_sample=0x00C0_0000.
- **Saturation:** all samples 0x7FFF_FFFF with SHIFT=0 → out_sample=0x7FFF_FFFF. All samples 0x8000_0000 → out_sample=0x8000_0000. No frame_err in either case.
- **Mask:** mask 0x008; voice 3 sample 0x10, others 0x1000; SHIFT=4 → out_sample=0x0000_0001.
- **Sequence error:** idx 0,1,2,5 → frame_err=1, busy=0, no out_valid. Then a clean 0..11 frame → correct output. clr_flags → frame_err=0.
- **Overrun/handshake:**
  - out_ready=0, frame A then frame B → out_sample=B, overrun=1, out_valid=1.
  - Assert out_ready for one cycle → out_valid=0 next cycle.
  - Transfer coincident with a completion → out_valid stays 1 with the new value.
- **Reset mid-frame:** Reset_n low after idx 5 → all outputs 0 immediately. Release, then feed idx 6..11 → frame_err=1 and no output. A full frame afterward produces the correct output.
